// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL bit positions and word-offset decode for mmio_timer.
package mmio_timer_pkg;

  localparam logic [3:0] TIMER_CTRL     = 4'h0;
  localparam logic [3:0] TIMER_PRESCALE = 4'h4;
  localparam logic [3:0] TIMER_COUNT    = 4'h8;
  localparam logic [3:0] TIMER_COMPARE  = 4'hC;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_AUTO  = 1;
  localparam int unsigned CTRL_IRQEN = 2;
  localparam int unsigned CTRL_FLAG  = 8;

  typedef enum logic [1:0] {
    REG_CTRL     = TIMER_CTRL[3:2],
    REG_PRESCALE = TIMER_PRESCALE[3:2],
    REG_COUNT    = TIMER_COUNT[3:2],
    REG_COMPARE  = TIMER_COMPARE[3:2]
  } reg_sel_e;

  function automatic reg_sel_e reg_of(input logic [1:0] word);
    return reg_sel_e'(word);
  endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// furv data-bus responder interface as seen by the timer peripheral.
interface mmio_timer_if;
  logic        sel;
  logic        mem_en;
  logic        mem_write;
  logic [3:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output sel, mem_en, mem_write, addr, data_in, input data_out, ack);
  modport slave  (input sel, mem_en, mem_write, addr, data_in, output data_out, ack);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescaler: counts 0..reload while enabled and pulses tick_o on reaching reload.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] reload_i,
  input  logic                  clear_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = enable_i && (cnt_q == reload_i);
    cnt_d  = cnt_q + 1'b1;
    if (!enable_i || clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare, sticky match flag and level irq.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W    = 16,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  logic                  en_q, en_d;
  logic                  auto_q, auto_d;
  logic                  irqen_q, irqen_d;
  logic                  flag_q, flag_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ack_q, ack_d;

  logic       wr, rd, tick, match;
  logic [31:0] rd_val;
  reg_sel_e   rsel;
  logic       addr_unused;

  assign addr_unused = ^bus.addr[1:0];
  assign rsel  = reg_of(bus.addr[3:2]);
  assign wr    = bus.sel && bus.mem_en && bus.mem_write;
  assign rd    = bus.sel && bus.mem_en && !bus.mem_write && !ack_q;
  assign match = tick && (count_q == compare_q);

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable_i (en_q),
    .reload_i (prescale_q),
    .clear_i  (wr && rsel == REG_PRESCALE),
    .tick_o   (tick)
  );

  always_comb begin
    rd_val = '0;
    unique case (rsel)
      REG_CTRL: begin
        rd_val[CTRL_EN]    = en_q;
        rd_val[CTRL_AUTO]  = auto_q;
        rd_val[CTRL_IRQEN] = irqen_q;
        rd_val[CTRL_FLAG]  = flag_q;
      end
      REG_PRESCALE: rd_val = 32'(prescale_q);
      REG_COUNT:    rd_val = count_q;
      REG_COMPARE:  rd_val = compare_q;
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    irqen_d    = irqen_q;
    flag_d     = flag_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    rdata_d    = rdata_q;
    ack_d      = rd;

    if (tick) count_d = (match && auto_q) ? '0 : count_q + 32'd1;

    // Bus writes override the tick update; match set takes priority over clear.
    if (wr) begin
      unique case (rsel)
        REG_CTRL: begin
          en_d    = bus.data_in[CTRL_EN];
          auto_d  = bus.data_in[CTRL_AUTO];
          irqen_d = bus.data_in[CTRL_IRQEN];
          if (bus.data_in[CTRL_FLAG]) flag_d = 1'b0;
        end
        REG_PRESCALE: prescale_d = bus.data_in[PRESCALE_W-1:0];
        REG_COUNT:    count_d    = bus.data_in;
        REG_COMPARE:  compare_d  = bus.data_in;
        default: ;
      endcase
    end
    if (match) flag_d = 1'b1;

    if (rd) rdata_d = rd_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irqen_q    <= 1'b0;
      flag_q     <= 1'b0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= RESET_COMPARE;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      irqen_q    <= irqen_d;
      flag_q     <= flag_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.data_out = rdata_q;
  assign bus.ack      = ack_q;
  assign irq          = flag_q & irqen_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: reads push expected data, a negedge monitor checks acks.
module tb_mmio_timer;
  import mmio_timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  mmio_timer_if bus ();

  mmio_timer #(.PRESCALE_W(16), .RESET_COMPARE(32'hFFFF_FFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int unsigned assert_cnt = 0;
  int unsigned fail_cnt   = 0;
  int unsigned ack_cnt    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected read response.
  always @(negedge clk) begin
    if (!rst && bus.ack) begin
      exp_t e;
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", bus.data_out, 32'hx);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("read_%h", e.addr), bus.data_out, e.data);
      end
    end
  end

  task automatic bus_idle();
    bus.sel = 1'b0; bus.mem_en = 1'b0; bus.mem_write = 1'b0;
    bus.addr = '0; bus.data_in = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.mem_en = 1'b1; bus.mem_write = 1'b1;
    bus.addr = a; bus.data_in = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    exp_t e;
    e.data = exp; e.addr = a;
    exp_q.push_back(e);
    bus.sel = 1'b1; bus.mem_en = 1'b1; bus.mem_write = 1'b0; bus.addr = a;
    @(posedge clk); #1;
    bus_idle();
    check("ack_latency", 32'(bus.ack), 32'd1);
    @(posedge clk); #1;
    check("ack_single_pulse", 32'(bus.ack), 32'd0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected %0d", 0);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    bus_idle();
    idle(2);
    rst = 1'b0;

    // Reset state
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_data_out", bus.data_out, 32'd0);
    rd(TIMER_COMPARE, 32'hFFFF_FFFF);
    rd(TIMER_CTRL, 32'h0);

    // PRESCALE=0, COMPARE=5, auto reload + irq
    wr(TIMER_PRESCALE, 32'd0);
    wr(TIMER_COMPARE, 32'd5);
    wr(TIMER_CTRL, 32'h7);
    rd(TIMER_COUNT, 32'd0);
    rd(TIMER_COUNT, 32'd2);
    idle(1);
    check("irq_before_match", 32'(irq), 32'd0);
    idle(1);
    check("irq_after_match", 32'(irq), 32'd1);
    rd(TIMER_COUNT, 32'd0);
    rd(TIMER_CTRL, 32'h107);
    wr(TIMER_CTRL, 32'h100);
    check("irq_after_clear", 32'(irq), 32'd0);

    // PRESCALE=3: one tick per 4 clocks, then frozen
    wr(TIMER_PRESCALE, 32'd3);
    wr(TIMER_COUNT, 32'd0);
    wr(TIMER_CTRL, 32'h1);
    idle(40);
    wr(TIMER_CTRL, 32'h0);
    idle(20);
    rd(TIMER_COUNT, 32'd10);
    rd(TIMER_CTRL, 32'h100);

    // Wrap through 0xFFFF_FFFF without flag, match at 0x10 without reload
    wr(TIMER_CTRL, 32'h100);
    wr(TIMER_PRESCALE, 32'd0);
    wr(TIMER_COMPARE, 32'h10);
    wr(TIMER_COUNT, 32'hFFFF_FFFE);
    wr(TIMER_CTRL, 32'h5);
    rd(TIMER_COUNT, 32'hFFFF_FFFE);
    rd(TIMER_COUNT, 32'h0);
    rd(TIMER_CTRL, 32'h5);
    idle(12);
    check("irq_before_0x10", 32'(irq), 32'd0);
    idle(1);
    check("irq_at_0x10", 32'(irq), 32'd1);
    rd(TIMER_COUNT, 32'h11);

    // Clear in the match cycle: set wins
    wr(TIMER_CTRL, 32'h100);
    wr(TIMER_COUNT, 32'd0);
    wr(TIMER_COMPARE, 32'd3);
    wr(TIMER_CTRL, 32'h5);
    idle(3);
    wr(TIMER_CTRL, 32'h105);
    check("set_beats_clear", 32'(irq), 32'd1);
    rd(TIMER_CTRL, 32'h105);
    wr(TIMER_CTRL, 32'h105);
    check("clear_outside_match", 32'(irq), 32'd0);

    // COUNT write in a tick cycle wins over the increment
    wr(TIMER_COUNT, 32'h100);
    rd(TIMER_COUNT, 32'h100);
    wr(TIMER_COMPARE, 32'h102);
    check("compare_write_uses_old", 32'(irq), 32'd0);
    wr(TIMER_COMPARE, 32'h104);
    wr(TIMER_COUNT, 32'h200);
    check("match_on_old_count", 32'(irq), 32'd1);
    rd(TIMER_COUNT, 32'h200);
    wr(TIMER_CTRL, 32'h100);

    // Held read: ack every second cycle
    base = ack_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.data = 32'h104; e.addr = TIMER_COMPARE;
      exp_q.push_back(e);
    end
    bus.sel = 1'b1; bus.mem_en = 1'b1; bus.mem_write = 1'b0; bus.addr = TIMER_COMPARE;
    idle(6);
    check("held_read_ack_after", 32'(bus.ack), 32'd0);
    bus_idle();
    check("held_read_ack_count", 32'(ack_cnt - base), 32'd3);

    // Reset while the ack is pending
    bus.sel = 1'b1; bus.mem_en = 1'b1; bus.mem_write = 1'b0; bus.addr = TIMER_CTRL;
    @(posedge clk); #1;
    rst = 1'b1;
    bus_idle();
    #1;
    check("rst_drops_ack", 32'(bus.ack), 32'd0);
    check("rst_clears_data_out", bus.data_out, 32'd0);
    idle(2);
    rst = 1'b0;
    check("rst_irq", 32'(irq), 32'd0);
    rd(TIMER_COMPARE, 32'hFFFF_FFFF);
    rd(TIMER_PRESCALE, 32'd0);
    rd(TIMER_COUNT, 32'd0);

    idle(2);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral; a responder on the furv data bus (mem_en / mem_write / addr / write data / read data / read_ack), sitting beside ram, uart and the LED register.
- Runs a prescaled 32-bit up-counter, a compare register and a sticky match flag, and drives a level interrupt output.
- The top-level decodes the address window and drives sel; the block decodes only the word offset.

Parameters:
- PRESCALE_W, 16, width of the prescaler reload register and prescaler counter.
- RESET_COMPARE, 32'hFFFF_FFFF, reset value of COMPARE.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  address window decode from top-level.
- mem_en  in  1  bus access strobe from initiator.
- mem_write  in  1  1 = write, 0 = read; qualified by mem_en.
- addr  in  4  byte offset in window; addr[3:2] selects the register, addr[1:0] is ignored.
- data_in  in  32  write data from initiator.
- data_out  out  32  read data, registered, valid while ack = 1.
- ack  out  1  read acknowledge, one-cycle pulse.
- irq  out  1  level interrupt = match_flag & irq_en.

Behaviour:
- Register map:
  - 0x0 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en, bit8 match_flag (read; write 1 clears), other bits read 0.
  - 0x4 PRESCALE: bits [PRESCALE_W-1:0].
  - 0x8 COUNT.
  - 0xC COMPARE.
- Reset (async): CTRL = 0, PRESCALE = 0, prescaler counter = 0, COUNT = 0, COMPARE = RESET_COMPARE, data_out = 0, ack = 0, irq = 0. Reset mid-access drops any pending ack.
- Write access:
  - Accepted in any cycle where sel & mem_en & mem_write.
  - Takes effect at that clock edge; no ack is generated.
  - Writes have no wait state.
- Read access:
  - Request is sampled when sel & mem_en & !mem_write & !ack.
  - Next cycle: ack = 1 and data_out holds the register value as of the sampling edge.
  - ack is a single-cycle pulse. A request present during an ack cycle is ignored, so a continuously held read acks every second cycle.
  - data_out holds its value between reads.
  - Reading has no side effects; the flag clears only on a write-1 to CTRL bit8.
- Prescaler:
  - Runs only while enable = 1.
  - Counts 0..PRESCALE and issues a one-cycle tick when its value equals PRESCALE, then reloads to 0.
  - PRESCALE = 0 gives a tick every cycle.
  - While enable = 0, the prescaler is held at 0 and COUNT is frozen.
  - Writing PRESCALE clears the prescaler counter.
- Count update on tick:
  - If COUNT == COMPARE: set match_flag; COUNT <= auto_reload ? 0 : COUNT + 1.
  - Otherwise COUNT <= COUNT + 1, wrapping mod 2^32 (0xFFFF_FFFF -> 0, no flag unless it matches COMPARE).
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the bus write wins; the tick is discarded, but match detection on the old COUNT still sets the flag.
  - Match set and write-1-clear in the same cycle: set wins, flag stays 1.
  - Write to COMPARE in a tick cycle: the comparison uses the old COMPARE.
  - Write to CTRL writes enable/auto_reload/irq_en; bit8 acts as clear-only.
- irq is combinational from flops (no extra latency): it follows match_flag & irq_en in the same cycle those registers change.

Decomposition:
- Shared package mmio_timer_pkg holds:
  - register offset constants (TIMER_CTRL = 4'h0, TIMER_PRESCALE = 4'h4, TIMER_COUNT = 4'h8, TIMER_COMPARE = 4'hC);
  - CTRL bit index constants (CTRL_EN = 0, CTRL_AUTO = 1, CTRL_IRQEN = 2, CTRL_FLAG = 8).
- One sub-module is natural: timer_prescaler (clk, rst, enable, reload value, clear, tick out). Bus decode, COUNT/COMPARE and the flag stay in mmio_timer.

Test Plan:
- Reset with the bus idle -> irq = 0, ack = 0; read 0xC returns 0xFFFF_FFFF with ack exactly 1 cycle after the request; read 0x0 returns 0.
- PRESCALE = 0, COMPARE = 5, CTRL = 0x7 -> COUNT 0,1,..,5 on consecutive cycles; match_flag and irq rise the cycle after COUNT = 5 is evaluated; COUNT returns to 0 and the flag stays set; write 0x100 to CTRL -> irq falls.
- PRESCALE = 3, CTRL = 0x1 -> COUNT increments once per 4 clocks; after 40 enabled cycles read COUNT = 10; CTRL = 0 -> COUNT stays frozen over 20 cycles.
- COUNT = 0xFFFF_FFFE, COMPARE = 0x10, auto_reload = 0, PRESCALE = 0 -> COUNT goes 0xFFFF_FFFF, 0x0, 0x1 with no flag; flag sets at COUNT = 0x10 and the counter continues to 0x11.
- Write-1-clear to CTRL bit8 issued in the exact match cycle -> flag remains 1. A COUNT write of 0x100 in a tick cycle -> COUNT reads 0x100 next, not 0x101.
- mem_en read held high for 6 cycles -> exactly 3 ack pulses on alternating cycles; rst asserted during the ack-pending cycle -> no ack and data_out = 0.
